serial_tc_decoder: RTL and testbench
====================================

// Module: serial_tc_decoder
// PURPOSE
//   Receive end of the bit-serial two's-complement link: accepts a W-bit
//   two's-complement word LSB-first, one bit per accepted cycle.
//   Reassembles the word and presents it in parallel as sign + magnitude.
//   Negation runs on the fly with the serial rule: copy bits up to and including
//   the first 1, then invert.
//   Sits after the serial negator/transmitter, feeding parallel datapath logic.
// PARAMETERS
//   W        8    word width in bits (W >= 2)
// PORTS
//   clk        in   1   rising-edge clock, single clock domain
//   reset      in   1   asynchronous, active-low reset
//   in_valid   in   1   serial bit on 'in' is valid this cycle
//   start      in   1   qualifies first bit (LSB) of a frame; sampled only with in_valid
//   in         in   1   serial data bit, LSB first
//   out_mag    out  W   magnitude |x|, unsigned (-2^(W-1) -> 2^(W-1), fits in W bits)
//   out_neg    out  1   sign of x (1 = negative); 0 for x == 0
//   out_valid  out  1   one-cycle pulse: out_mag/out_neg updated this cycle
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, bit count=0, shift regs=0,
//     out_mag=0, out_neg=0, out_valid=0.
//   States: IDLE, RECV.
//   IDLE:
//     in_valid&start -> capture bit 0, count=1, -> RECV.
//     in_valid&!start: bit ignored, stay IDLE.
//   RECV: each in_valid cycle shifts 'in' into raw reg and the negated bit into neg reg.
//     The negated bit is in while seen_one==0, else ~in.
//     seen_one sets after the first accepted 1 (bit 0 included).
//     count increments on each accepted bit.
//   in_valid==0: full hold (no shift, no count change), any number of cycles.
//   in_valid&start in RECV: abort current frame, no output.
//     The bit is taken as bit 0 of a new frame (count=1, seen_one=in).
//   W-th bit accepted: sign = that bit (MSB).
//     Next rising edge: out_mag = sign ? neg : raw, out_neg = sign, out_valid=1 for one cycle.
//     state -> IDLE.
//   Latency: out_valid exactly 1 cycle after the edge accepting the MSB.
//   Back-to-back frames are allowed: a start bit in the same cycle
//     out_valid is high is accepted (IDLE entered at that edge).
//   out_mag/out_neg hold their last value between pulses.
//   No partial or aborted frame ever produces out_valid.
//   Width rule: magnitude of -2^(W-1) is the W-bit pattern 1000..0; no overflow flag.
//   Reset mid-frame: frame discarded, outputs to reset values immediately.
// TESTING
//   W=8, 0x05 LSB-first 1,0,1,0,0,0,0,0 back-to-back valid
//     -> 1 cycle after MSB: out_valid=1, out_mag=5, out_neg=0.
//   0xFB (-5) bits 1,1,0,1,1,1,1,1
//     -> out_mag=0x05, out_neg=1.
//   0x80 (-128) bits 0,0,0,0,0,0,0,1
//     -> out_mag=0x80, out_neg=1.
//   0x00
//     -> out_mag=0, out_neg=0.
//   0xFB with in_valid low 3 cycles after bit 2
//     -> same result, out_valid delayed by 3 cycles, single pulse.
//   Restart: 4 bits sent, then start with 0x03, or reset low after 5 bits
//     -> out_mag=3, out_neg=0 only; for the reset case, no pulse and outputs 0.
//   Back-to-back: 0x05 then 0xFF with start on the cycle after the first MSB
//     -> two pulses 8 cycles apart: (5,0), then (1,1).

Source files
------------

// File: rtl/serial_tc_decoder_if.sv
// Bit-serial two's-complement receive link: serial input side plus the
// parallel sign/magnitude result side.
interface serial_tc_decoder_if #(
    parameter int unsigned W = 8
) ();
    logic         in_valid;
    logic         start;
    logic         in;
    logic [W-1:0] out_mag;
    logic         out_neg;
    logic         out_valid;

    modport master (
        output in_valid, start, in,
        input  out_mag, out_neg, out_valid
    );

    modport slave (
        input  in_valid, start, in,
        output out_mag, out_neg, out_valid
    );
endinterface

// File: rtl/serial_tc_decoder.sv
// Reassembles an LSB-first two's-complement word and presents it as
// sign + magnitude, negating on the fly with the copy-to-first-one rule.
module serial_tc_decoder #(
    parameter int unsigned W = 8
) (
    input  logic                clk,
    input  logic                reset,
    serial_tc_decoder_if.slave  bus
);
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [W-1:0]  raw;
    logic [W-1:0]  neg;
    logic          seen_one;
    logic          done;

    logic          neg_bit;
    logic          last_bit;

    assign neg_bit  = seen_one ? ~bus.in : bus.in;
    assign last_bit = (count == CW'(W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            raw           <= '0;
            neg           <= '0;
            seen_one      <= 1'b0;
            done          <= 1'b0;
            bus.out_mag   <= '0;
            bus.out_neg   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            // Result is published one edge after the MSB; a new frame may be
            // shifting in at that same edge, which only touches raw/neg next.
            bus.out_valid <= done;
            if (done) begin
                bus.out_neg <= raw[W-1];
                bus.out_mag <= raw[W-1] ? neg : raw;
            end
            done <= 1'b0;

            if (bus.in_valid) begin
                if (bus.start) begin
                    // Start always opens a fresh frame, aborting any partial one.
                    raw      <= {bus.in, raw[W-1:1]};
                    neg      <= {bus.in, neg[W-1:1]};
                    seen_one <= bus.in;
                    count    <= CW'(1);
                    state    <= RECV;
                end else if (state == RECV) begin
                    raw      <= {bus.in, raw[W-1:1]};
                    neg      <= {neg_bit, neg[W-1:1]};
                    seen_one <= seen_one | bus.in;
                    if (last_bit) begin
                        count <= '0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_tc_decoder.sv
// Bench for serial_tc_decoder: frame-level value model, per-cycle compare,
// literal checks on directed frames, then randomized traffic.
module tb_serial_tc_decoder;
    localparam int unsigned W = 8;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    serial_tc_decoder_if #(.W(W)) bus ();

    serial_tc_decoder #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Magnitude of a W-bit two's-complement word, via its integer value.
    function automatic logic [W-1:0] mag_of(logic [W-1:0] w);
        int v;
        v = int'(w);
        if (w[W-1]) v = v - (1 << W);
        if (v < 0) v = -v;
        return W'(v);
    endfunction

    // Frame-level model: collect bits into a word, publish one edge later.
    logic [W-1:0] m_bits, word_nx, m_pmag, e_mag;
    int           m_n, n_nx;
    logic         m_active, m_pend, m_pneg, e_neg, e_valid;

    always_comb begin
        word_nx = bus.start ? W'(bus.in) : (m_bits | (W'(bus.in) << m_n));
        n_nx    = bus.start ? 1 : m_n + 1;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_bits <= '0; m_n <= 0; m_active <= 1'b0; m_pend <= 1'b0;
            m_pmag <= '0; m_pneg <= 1'b0;
            e_mag <= '0; e_neg <= 1'b0; e_valid <= 1'b0;
        end else begin
            e_valid <= m_pend;
            if (m_pend) begin
                e_mag <= m_pmag;
                e_neg <= m_pneg;
            end
            m_pend <= 1'b0;
            if (bus.in_valid && (bus.start || m_active)) begin
                if (n_nx == W) begin
                    m_pend   <= 1'b1;
                    m_pmag   <= mag_of(word_nx);
                    m_pneg   <= word_nx[W-1];
                    m_active <= 1'b0;
                    m_n      <= 0;
                    m_bits   <= '0;
                end else begin
                    m_active <= 1'b1;
                    m_n      <= n_nx;
                    m_bits   <= word_nx;
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0] mag;
        logic         neg;
        int           cyc;
    } pulse_t;
    pulse_t pulses[$];

    always @(negedge clk) begin
        check("out_valid", int'(bus.out_valid), int'(e_valid));
        check("out_mag", int'(bus.out_mag), int'(e_mag));
        check("out_neg", int'(bus.out_neg), int'(e_neg));
        if (bus.out_valid) pulses.push_back('{bus.out_mag, bus.out_neg, cyc});
    end

    task automatic drive(input logic v, input logic s, input logic b);
        @(posedge clk);
        #2;
        bus.in_valid = v;
        bus.start    = s;
        bus.in       = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] w, input int gap_at, input int gap_len,
                        output int sc);
        sc = 0;
        for (int i = 0; i < int'(W); i++) begin
            drive(1'b1, i == 0, w[i]);
            if (i == 0) sc = cyc;
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) drive(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic expect_one(string name, int mag, int neg);
        check({name, " pulses"}, pulses.size(), 1);
        if (pulses.size() >= 1) begin
            check({name, " mag"}, int'(pulses[0].mag), mag);
            check({name, " neg"}, int'(pulses[0].neg), neg);
        end
    endtask

    initial begin
        int sc, sc2;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        bus.in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_mag", int'(bus.out_mag), 0);
        check("reset out_neg", int'(bus.out_neg), 0);
        @(posedge clk);
        #2 reset = 1'b1;
        idle(2);

        pulses.delete();
        send(8'h05, -1, 0, sc); idle(3);
        expect_one("pos5", 5, 0);
        if (pulses.size() >= 1) check("pos5 latency", pulses[0].cyc - sc, W + 1);

        pulses.delete();
        send(8'hFB, -1, 0, sc); idle(3);
        expect_one("neg5", 5, 1);

        pulses.delete();
        send(8'h80, -1, 0, sc); idle(3);
        expect_one("min", 128, 1);

        pulses.delete();
        send(8'h00, -1, 0, sc); idle(3);
        expect_one("zero", 0, 0);

        pulses.delete();
        send(8'hFB, 2, 3, sc); idle(3);
        expect_one("gap", 5, 1);
        if (pulses.size() >= 1) check("gap latency", pulses[0].cyc - sc, W + 4);

        pulses.delete();
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b1);
        send(8'h03, -1, 0, sc); idle(3);
        expect_one("restart", 3, 0);

        pulses.delete();
        drive(1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset out_mag", int'(bus.out_mag), 0);
        check("midreset out_neg", int'(bus.out_neg), 0);
        check("midreset out_valid", int'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        bus.in_valid = 1'b0;
        idle(W + 3);
        check("midreset pulses", pulses.size(), 0);

        pulses.delete();
        send(8'h05, -1, 0, sc);
        send(8'hFF, -1, 0, sc2);
        idle(3);
        check("b2b pulses", pulses.size(), 2);
        if (pulses.size() >= 2) begin
            check("b2b first mag", int'(pulses[0].mag), 5);
            check("b2b first neg", int'(pulses[0].neg), 0);
            check("b2b second mag", int'(pulses[1].mag), 1);
            check("b2b second neg", int'(pulses[1].neg), 1);
            check("b2b spacing", pulses[1].cyc - pulses[0].cyc, 8);
        end

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                @(posedge clk);
                #2 reset = 1'b0;
                @(posedge clk);
                #2 reset = 1'b1;
            end
            drive(($urandom % 4) != 0, ($urandom % 10) == 0, 1'($urandom));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
